oai_sweep_tester: RTL

- Parametrised exhaustive-sweep tester for multi-input OAI/AOI complex-gate cells.
- Drives every one of the 2^N input combinations onto an external gate under test, waits a programmable settle time, then samples the gate output.
- Compares each sample against an internal golden model, counts mismatches and records the first failing vector.
- Sits between a gate-level cell and the bench or top-level pass/fail reporting; replaces hand-written per-vector stimulus lists.

---
 rtl/oai_sweep_tester.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/oai_sweep_tester.sv
// Exhaustive-sweep tester for OAI/AOI complex gates: walks every input vector,
// compares the gate output with a golden model. Optional macro: STOP_ON_FAIL_EN.
module oai_sweep_tester #(
  parameter  int GRP_W  = 2,
  parameter  int N_GRP  = 2,
  parameter  int SETTLE = 1,
  parameter  int ERR_W  = 8,
  localparam int N      = GRP_W * N_GRP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [N-1:0]     stim,
  input  logic             dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     first_fail,
  output logic             first_fail_vld
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     stim_q, stim_d;
  logic             mode_q, mode_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [N-1:0]     ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             mismatch;
  logic             stop;

  // m=0: ~AND of group ORs (OAI); m=1: ~OR of group ANDs (AOI)
  function automatic logic golden(input logic [N-1:0] v, input logic m);
    logic acc_and;
    logic acc_or;
    acc_and = 1'b1;
    acc_or  = 1'b0;
    for (int g = 0; g < N_GRP; g++) begin
      acc_and = acc_and & (|v[g*GRP_W +: GRP_W]);
      acc_or  = acc_or  | (&v[g*GRP_W +: GRP_W]);
    end
    return m ? ~acc_or : ~acc_and;
  endfunction

  assign mismatch = (dut_f != golden(stim_q, mode_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    mode_d  = mode_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    stop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          err_d   = '0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
          stim_d  = '0;
          cnt_d   = SETTLE_LD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        stop = (stim_q == '1);
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ff_d  = stim_q;
            ffv_d = 1'b1;
          end
`ifdef STOP_ON_FAIL_EN
          stop = 1'b1;
`else
          stop = stop;
`endif
        end
        // pass reflects the final count, including this last comparison
        if (stop) begin
          pass_d  = ~mismatch & (err_q == '0);
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stim           = stim_q;
  assign busy           = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule
